// File: rtl/cpu_queue.sv
`default_nettype none
// ============================================================================
// Module      : cpu_queue
// Description : 32-bit FIFO with the CPU stack's push/pop/clear/hold/flush
//               interface; registered read data, status and sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================

module cpu_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic                       hold,
    input  logic                       flush,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_q;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_active;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_depth);
    assign w_active = !flush && !clear && !hold;

    // On a full queue a simultaneous pop frees the slot the push needs.
    // On an empty queue the pop is refused; there is no write-through bypass.
    assign w_push_acc = w_active && push && (!w_full || pop);
    assign w_pop_acc  = w_active && pop && !w_empty;
    assign w_ovf_set  = w_active && push && w_full && !pop;
    assign w_unf_set  = w_active && pop && w_empty;

    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            mem[r_wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_q         <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_q         <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clear) begin
            r_q <= '0;
        end else if (!hold) begin
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_q      <= mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - 1'b1;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign q         = r_q;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_cpu_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_queue
// Description : Directed, table-driven self-checking bench for cpu_queue.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cpu_queue;

    logic        clk;
    logic        reset_n;
    logic [31:0] d;
    logic [31:0] q;
    logic        push;
    logic        pop;
    logic        clear;
    logic        hold;
    logic        flush;
    logic        empty;
    logic        full;
    logic [7:0]  count;
    logic        overflow;
    logic        underflow;

    int n_cmp = 0;
    int n_err = 0;

    cpu_queue #(.WIDTH(32), .DEPTH(128)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d         (d),
        .q         (q),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .hold      (hold),
        .flush     (flush),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        clear;
        logic        hold;
        logic        flush;
        logic [31:0] d;
        logic [31:0] q;
        int          cnt;
        logic        em;
        logic        fu;
        logic        ov;
        logic        un;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string tag, input string fld,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] eq, input int ec,
                           input logic ee, input logic ef, input logic eo, input logic eu);
        chk(tag, "q", q, eq);
        chk(tag, "count", 32'(count), 32'(ec));
        chk(tag, "empty", 32'(empty), 32'(ee));
        chk(tag, "full", 32'(full), 32'(ef));
        chk(tag, "overflow", 32'(overflow), 32'(eo));
        chk(tag, "underflow", 32'(underflow), 32'(eu));
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic pu, input logic po, input logic cl,
                        input logic ho, input logic fl, input logic [31:0] dv);
        push = pu; pop = po; clear = cl; hold = ho; flush = fl; d = dv;
        @(posedge clk);
        #1;
        push = 0; pop = 0; clear = 0; hold = 0; flush = 0;
    endtask

    initial begin
        //          pu po cl ho fl  d             q             cnt em fu ov un
        tbl[0]  = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        0,  1, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 32'h11,       32'h0,        1,  0, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 32'h22,       32'h0,        2,  0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 32'h33,       32'h0,        3,  0, 0, 0, 0};
        tbl[4]  = '{0, 1, 0, 0, 0, 32'h0,        32'h11,       2,  0, 0, 0, 0};
        tbl[5]  = '{0, 1, 0, 0, 0, 32'h0,        32'h22,       1,  0, 0, 0, 0};
        tbl[6]  = '{0, 1, 0, 0, 0, 32'h0,        32'h33,       0,  1, 0, 0, 0};
        tbl[7]  = '{1, 1, 0, 0, 0, 32'h44,       32'h33,       1,  0, 0, 0, 1};
        tbl[8]  = '{0, 1, 0, 0, 0, 32'h0,        32'h44,       0,  1, 0, 0, 1};
        tbl[9]  = '{1, 0, 0, 0, 0, 32'hA1,       32'h44,       1,  0, 0, 0, 1};
        tbl[10] = '{1, 0, 0, 0, 0, 32'hA2,       32'h44,       2,  0, 0, 0, 1};
        tbl[11] = '{1, 0, 0, 0, 0, 32'hA3,       32'h44,       3,  0, 0, 0, 1};
        tbl[12] = '{1, 0, 0, 0, 0, 32'hA4,       32'h44,       4,  0, 0, 0, 1};
        tbl[13] = '{1, 1, 0, 1, 0, 32'hFF,       32'h44,       4,  0, 0, 0, 1};
        tbl[14] = '{1, 1, 1, 0, 0, 32'h55,       32'h0,        4,  0, 0, 0, 1};
        tbl[15] = '{0, 1, 0, 0, 0, 32'h0,        32'hA1,       3,  0, 0, 0, 1};
        tbl[16] = '{1, 0, 0, 0, 1, 32'h66,       32'h0,        0,  1, 0, 0, 0};
        tbl[17] = '{0, 1, 0, 0, 0, 32'h0,        32'h0,        0,  1, 0, 0, 1};
        tbl[18] = '{0, 0, 0, 0, 1, 32'h0,        32'h0,        0,  1, 0, 0, 0};

        reset_n = 1; push = 0; pop = 0; clear = 0; hold = 0; flush = 0; d = '0;
        #1 reset_n = 0;
        #21 reset_n = 1;

        foreach (tbl[i]) begin
            step(tbl[i].push, tbl[i].pop, tbl[i].clear, tbl[i].hold, tbl[i].flush, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].q, tbl[i].cnt,
                    tbl[i].em, tbl[i].fu, tbl[i].ov, tbl[i].un);
        end

        // Fill to capacity, then push+pop on full, then a dropped push.
        for (int i = 0; i < 128; i++) begin
            step(1, 0, 0, 0, 0, 32'h100 + 32'(i));
            chk("fill", "count", 32'(count), 32'(i + 1));
        end
        chk_all("full", 32'h0, 128, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 32'h180);
        chk_all("pushpop_full", 32'h100, 128, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 32'hDEAD);
        chk_all("drop", 32'h100, 128, 0, 1, 1, 0);
        for (int i = 0; i < 128; i++) begin
            step(0, 1, 0, 0, 0, 32'h0);
            chk("drain", "q", q, 32'h101 + 32'(i));
            chk("drain", "count", 32'(count), 32'(127 - i));
        end
        chk_all("drained", 32'h180, 0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 1, 32'h0);
        chk_all("flush2", 32'h0, 0, 1, 0, 0, 0);

        // Pointer wrap with a steady occupancy of five.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 32'h1000 + 32'(i));
        end
        chk("prefill", "count", 32'(count), 32'd5);
        for (int k = 0; k < 200; k++) begin
            step(1, 1, 0, 0, 0, 32'h1005 + 32'(k));
            chk("wrap", "q", q, 32'h1000 + 32'(k));
            chk("wrap", "count", 32'(count), 32'd5);
        end
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 0, 0, 32'h0);
            chk("tail", "q", q, 32'h1000 + 32'(200 + k));
        end
        chk_all("wrap_end", 32'h10CC, 0, 1, 0, 0, 0);

        // Asynchronous reset in the middle of a push.
        step(1, 0, 0, 0, 0, 32'h77);
        chk("pre_rst", "count", 32'(count), 32'd1);
        push = 1; d = 32'h88;
        #2 reset_n = 0;
        #1;
        chk_all("async_rst", 32'h0, 0, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        chk_all("rst_held", 32'h0, 0, 1, 0, 0, 0);
        reset_n = 1; push = 0;
        step(0, 0, 0, 0, 0, 32'h0);
        chk_all("post_rst", 32'h0, 0, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
